// File: rtl/ipg_wreq_gen.sv
// ipg_wreq_gen: transmit side of the IPG write-request protocol.
// Accepts one write request and serialises it into the inter-packet-gap bit
// slots offered by the PCS: a 56-bit header chunk (len, addr), then payload
// chunks MSB first.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   req_valid/ready request handshake (ready only while idle)
//   req_addr/len    write address and payload length in bits
//   req_payload     payload, bits [req_len-1:0] valid, MSB sent first
//   gap_len         IPG bits granted for the next cycle
//   tx_ipg_data     MSB-aligned chunk, unused low bits zero
//   tx_len          bits used in tx_ipg_data
//   wreq_valid      chunk carries write-request data
//   req_done        pulse with the last chunk of a request
//   req_err         pulse when a request is rejected (too long)
module ipg_wreq_gen #(
  parameter int unsigned HDR_WIDTH   = 16,
  parameter int unsigned ADR_WIDTH   = 40,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PAYLOAD_LEN = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADR_WIDTH-1:0]          req_addr,
  input  logic [HDR_WIDTH-1:0]          req_len,
  input  logic [PAYLOAD_LEN-1:0]        req_payload,
  input  logic [$clog2(DATA_WIDTH)-1:0] gap_len,
  output logic [DATA_WIDTH-1:0]         tx_ipg_data,
  output logic [$clog2(DATA_WIDTH)-1:0] tx_len,
  output logic                          wreq_valid,
  output logic                          req_done,
  output logic                          req_err
);

  localparam int unsigned GAP_W    = $clog2(DATA_WIDTH);
  localparam int unsigned SH_W     = GAP_W + 1;
  localparam int unsigned HDR_BITS = HDR_WIDTH + ADR_WIDTH;
  localparam int unsigned PAD_W    = DATA_WIDTH - HDR_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADR_WIDTH-1:0]     addr_q, addr_d;
  logic [HDR_WIDTH-1:0]     len_q, len_d;
  logic [PAYLOAD_LEN-1:0]   payload_q, payload_d;
  logic [HDR_WIDTH-1:0]     rem_q, rem_d;
  logic [DATA_WIDTH-1:0]    data_d;
  logic [GAP_W-1:0]         txlen_d;
  logic                     wv_d, done_d, err_d, ready_d;
  logic [GAP_W-1:0]         n;
  logic [HDR_WIDTH-1:0]     shift;
  logic [DATA_WIDTH-1:0]    chunk;

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    payload_d = payload_q;
    rem_d     = rem_q;
    data_d    = '0;
    txlen_d   = '0;
    wv_d      = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    n         = '0;
    shift     = '0;
    chunk     = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d    = req_addr;
          len_d     = req_len;
          payload_d = req_payload;
          rem_d     = req_len;
          if (req_len > HDR_WIDTH'(PAYLOAD_LEN)) begin
            err_d = 1'b1;
          end else begin
            state_d = HDR;
          end
        end
      end

      HDR: begin
        // Header goes out whole; leftover gap bits in that cycle stay empty
        if (gap_len >= GAP_W'(HDR_BITS)) begin
          data_d  = {len_q, addr_q, PAD_W'(0)};
          txlen_d = GAP_W'(HDR_BITS);
          wv_d    = 1'b1;
          if (len_q == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (gap_len != '0) begin
          n     = (HDR_WIDTH'(gap_len) < rem_q) ? gap_len : GAP_W'(rem_q);
          shift = rem_q - HDR_WIDTH'(n);
          // Low n bits of the window hold payload[rem-1 -: n]; the left
          // shift both MSB-aligns them and drops everything above
          chunk   = DATA_WIDTH'(payload_q >> shift);
          data_d  = chunk << (SH_W'(DATA_WIDTH) - SH_W'(n));
          txlen_d = n;
          wv_d    = 1'b1;
          rem_d   = shift;
          if (shift == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Ready stays low in the cycle the last chunk is driven
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      payload_q   <= '0;
      rem_q       <= '0;
      tx_ipg_data <= '0;
      tx_len      <= '0;
      wreq_valid  <= 1'b0;
      req_done    <= 1'b0;
      req_err     <= 1'b0;
      req_ready   <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      payload_q   <= payload_d;
      rem_q       <= rem_d;
      tx_ipg_data <= data_d;
      tx_len      <= txlen_d;
      wreq_valid  <= wv_d;
      req_done    <= done_d;
      req_err     <= err_d;
      req_ready   <= ready_d;
    end
  end

endmodule
